// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns a decoded instruction request (type, op, register indices, immediate)
// into a 32-bit RV32I machine word. Each word is tagged with a running byte
// address and queued in a small output buffer for a downstream consumer.
// Requests with an illegal type are accepted, dropped and reported on err.
//
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN
//   When defined, out-of-range immediates and undefined func3/func7
//   combinations are also treated as illegal. When undefined, only
//   in_type=7 is illegal and immediates are silently truncated.
//
// Parameters
//   BASE_ADDR  address given to the first pushed word
//   DEPTH      output buffer entries (power of 2, >= 2)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready (buffer not full)
//   in_type    0=R 1=S 2=L 3=I 4=B 5=LU 6=AU 7=illegal
//   in_op      R/I: {func7[5], func3}; S/L/B: func3 in [2:0]
//   in_rd      destination register index
//   in_rs1     source register 1 index
//   in_rs2     source register 2 index
//   in_imm     immediate / byte offset / full upper value
//   out_valid  buffered word available
//   out_ready  consumer takes the word when out_valid && out_ready
//   out_instr  encoded word
//   out_addr   address tag of out_instr
//   err        one-cycle pulse after an illegal request was dropped
//   err_cnt    saturating count of dropped requests
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_L  = 7'b0000011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_B  = 7'b1100011;
  localparam logic [6:0] OPC_LU = 7'b0110111;
  localparam logic [6:0] OPC_AU = 7'b0010111;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_S   = 3'd1,
    TYPE_L   = 3'd2,
    TYPE_I   = 3'd3,
    TYPE_B   = 3'd4,
    TYPE_LU  = 3'd5,
    TYPE_AU  = 3'd6,
    TYPE_ILL = 3'd7
  } instr_type_e;

  instr_type_e instrType;
  logic [2:0]  func3;
  logic        isShift;
  logic [11:0] immI;
  logic [31:0] encWord;
  logic        legal;

  logic [31:0]   instrMem_q [DEPTH];
  logic [31:0]   addrMem_q  [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    errCnt_q, errCnt_d;

  logic full;
  logic accept;
  logic push;
  logic pop;
  logic drop;

  assign instrType = instr_type_e'(in_type);
  assign func3     = in_op[2:0];
  assign isShift   = (func3 == 3'b001) || (func3 == 3'b101);

  // Shift-immediate forms carry func7[5] in imm[10] and the shift amount in
  // imm[4:0]; every other I-form takes the low 12 immediate bits as-is.
  assign immI = isShift ? {1'b0, in_op[3], 5'b00000, in_imm[4:0]} : in_imm[11:0];

  always_comb begin
    encWord = 32'h0;
    case (instrType)
      TYPE_R:  encWord = {1'b0, in_op[3], 5'b00000, in_rs2, in_rs1, func3, in_rd, OPC_R};
      TYPE_I:  encWord = {immI, in_rs1, func3, in_rd, OPC_I};
      TYPE_L:  encWord = {in_imm[11:0], in_rs1, func3, in_rd, OPC_L};
      TYPE_S:  encWord = {in_imm[11:5], in_rs2, in_rs1, func3, in_imm[4:0], OPC_S};
      TYPE_B:  encWord = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, func3,
                          in_imm[4:1], in_imm[11], OPC_B};
      TYPE_LU: encWord = {in_imm[31:12], in_rd, OPC_LU};
      TYPE_AU: encWord = {in_imm[31:12], in_rd, OPC_AU};
      default: encWord = 32'h0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] immS;
  logic               imm12Ok;

  assign immS    = $signed(in_imm);
  assign imm12Ok = (immS >= -32'sd2048) && (immS <= 32'sd2047);

  // Only sub/sra may set func7[5] on R-type; branch func3 010/011 and the
  // load/store func3 holes have no RV32I instruction behind them.
  always_comb begin
    legal = 1'b1;
    case (instrType)
      TYPE_R:  legal = !in_op[3] || (func3 == 3'b000) || (func3 == 3'b101);
      TYPE_I:  legal = isShift ? ((immS >= 32'sd0) && (immS <= 32'sd31)) : imm12Ok;
      TYPE_L:  legal = imm12Ok && (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
      TYPE_S:  legal = imm12Ok && (func3 <= 3'b010);
      TYPE_B:  legal = !in_imm[0] && (immS >= -32'sd4096) && (immS <= 32'sd4094) &&
                       (func3 != 3'b010) && (func3 != 3'b011);
      TYPE_LU: legal = (in_imm[11:0] == 12'h000);
      TYPE_AU: legal = (in_imm[11:0] == 12'h000);
      default: legal = 1'b0;
    endcase
  end
`else
  assign legal = (instrType != TYPE_ILL);
`endif

  // Ready depends only on buffer occupancy (never on out_ready), and is held
  // low while reset is asserted.
  assign full      = (count_q == FULL_CNT);
  assign in_ready  = reset && !full;
  assign out_valid = (count_q != '0);
  assign out_instr = instrMem_q[rdPtr_q];
  assign out_addr  = addrMem_q[rdPtr_q];
  assign err       = err_q;
  assign err_cnt   = errCnt_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign drop   = accept && !legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = drop;
    errCnt_d = errCnt_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
      addr_d  = addr_q + 32'd4;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && (errCnt_q != 8'hFF)) begin
      errCnt_d = errCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
      errCnt_q <= 8'h00;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  // Buffer storage needs no reset: an entry is only visible once count_q
  // says it was written since the last reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= encWord;
      addrMem_q[wrPtr_q]  <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder (DEPTH=2). A table of encoding
// vectors, hand-written sequences for backpressure, illegal drops, reset and
// address wrap (second instance with BASE_ADDR=32'hFFFF_FFFC), then random
// traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady;
  logic [2:0]  inType;
  logic [3:0]  inOp;
  logic [4:0]  inRd, inRs1, inRs2;
  logic [31:0] inImm;
  logic        outValid, outReady;
  logic [31:0] outInstr, outAddr;
  logic        err;
  logic [7:0]  errCnt;

  logic        inValid2, inReady2, outValid2, err2;
  logic [31:0] outInstr2, outAddr2;
  logic [7:0]  errCnt2;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(inValid), .in_ready(inReady),
    .in_type(inType), .in_op(inOp),
    .in_rd(inRd), .in_rs1(inRs1), .in_rs2(inRs2), .in_imm(inImm),
    .out_valid(outValid), .out_ready(outReady),
    .out_instr(outInstr), .out_addr(outAddr),
    .err(err), .err_cnt(errCnt)
  );

  instr_encoder #(.BASE_ADDR(BASE2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(inValid2), .in_ready(inReady2),
    .in_type(3'd0), .in_op(4'b0000),
    .in_rd(5'd1), .in_rs1(5'd2), .in_rs2(5'd3), .in_imm(32'h0),
    .out_valid(outValid2), .out_ready(1'b1),
    .out_instr(outInstr2), .out_addr(outAddr2),
    .err(err2), .err_cnt(errCnt2)
  );

  typedef struct {
    string       name;
    logic [2:0]  t;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] expInstr;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  vec_t vecs[9];
  exp_t expQ[$];
  exp_t gotQ[$];

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drives the request side of the main instance.
  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [3:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    inValid = v;
    inType  = t;
    inOp    = op;
    inRd    = rd;
    inRs1   = rs1;
    inRs2   = rs2;
    inImm   = imm;
  endtask

  task automatic applyVec(input logic v, input vec_t x);
    applyStimulus(v, x.t, x.op, x.rd, x.rs1, x.rs2, x.imm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, checking the reset-state outputs meanwhile.
  task automatic doReset();
    reset    = 1'b0;
    outReady = 1'b0;
    inValid2 = 1'b0;
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(inReady), 32'd0);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready_after", 32'(inReady), 32'd1);
    tick();
  endtask

  // Reference encoding built by OR-ing each field into its bit position.
  function automatic logic [31:0] modelEncode(input logic [2:0] t, input logic [3:0] op,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] f3;
    logic [31:0] sh;
    f3 = 32'(op[2:0]);
    w  = (32'(rd) << 7) | (f3 << 12) | (32'(rs1) << 15);
    case (t)
      3'd0: w = w | 32'h33 | (32'(rs2) << 20) | (op[3] ? 32'h4000_0000 : 32'h0);
      3'd3: begin
        if (f3 == 32'd1 || f3 == 32'd5)
          sh = (op[3] ? 32'h400 : 32'h0) | (imm & 32'h1F);
        else
          sh = imm & 32'hFFF;
        w = w | 32'h13 | (sh << 20);
      end
      3'd2: w = w | 32'h03 | ((imm & 32'hFFF) << 20);
      3'd1: w = (f3 << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) | 32'h23 |
                ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
      3'd4: w = (f3 << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) | 32'h63 |
                (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd5: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37;
      3'd6: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h17;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic bit modelLegal(input logic [2:0] t, input logic [3:0] op,
                                    input logic [31:0] imm);
    bit ok;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    int s;
    int f3;
    s  = int'($signed(imm));
    f3 = int'(op[2:0]);
    case (t)
      3'd0: ok = !op[3] || f3 == 0 || f3 == 5;
      3'd3: ok = (f3 == 1 || f3 == 5) ? (s >= 0 && s <= 31) : (s >= -2048 && s <= 2047);
      3'd2: ok = (s >= -2048 && s <= 2047) && (f3 inside {0, 1, 2, 4, 5});
      3'd1: ok = (s >= -2048 && s <= 2047) && f3 <= 2;
      3'd4: ok = (s % 2 == 0) && s >= -4096 && s <= 4094 && f3 != 2 && f3 != 3;
      3'd5, 3'd6: ok = (imm[11:0] == 12'h0);
      default: ok = 1'b0;
    endcase
`else
    ok = (t != 3'd7);
`endif
    return ok;
  endfunction

  initial begin
    vec_t vA, vB, vC;
    int   imm;
    bit   v, legalNow, readyNow, acceptNow;
    logic [2:0]  t;
    logic [3:0]  op;
    logic [31:0] immV;
    logic [31:0] modelAddr;
    int   modelErrCnt;
    bit   modelErr;

    vecs[0] = '{"R_sub",  3'd0, 4'b1000, 5'd3,  5'd1,  5'd2, 32'd0,         32'h4020_81B3};
    vecs[1] = '{"B_neg8", 3'd4, 4'b0000, 5'd0,  5'd1,  5'd2, -32'sd8,       32'hFE20_8CE3};
    vecs[2] = '{"I_srai", 3'd3, 4'b1101, 5'd5,  5'd5,  5'd0, 32'd3,         32'h4032_D293};
    vecs[3] = '{"LU",     3'd5, 4'b0000, 5'd10, 5'd0,  5'd0, 32'h1234_5000, 32'h1234_5537};
    vecs[4] = '{"S_sw",   3'd1, 4'b0010, 5'd0,  5'd2,  5'd8, -32'sd4,       32'hFE81_2E23};
    vecs[5] = '{"L_lw",   3'd2, 4'b0010, 5'd5,  5'd10, 5'd0, 32'd16,        32'h0105_2283};
    vecs[6] = '{"I_addi", 3'd3, 4'b0000, 5'd1,  5'd0,  5'd0, -32'sd1,       32'hFFF0_0093};
    vecs[7] = '{"AU",     3'd6, 4'b0000, 5'd1,  5'd0,  5'd0, 32'h0000_1000, 32'h0000_1097};
    vecs[8] = '{"R_add",  3'd0, 4'b0000, 5'd1,  5'd2,  5'd3, 32'd0,         32'h0031_00B3};

    inValid2 = 1'b0;
    doReset();

    // Encoding table: one request at a time, output exactly one cycle later.
    outReady = 1'b1;
    foreach (vecs[i]) begin
      applyVec(1'b1, vecs[i]);
      @(negedge clk);
      checkOutput({vecs[i].name, "_ready"}, 32'(inReady), 32'd1);
      checkOutput({vecs[i].name, "_notyet"}, 32'(outValid), 32'd0);
      tick();
      applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
      @(negedge clk);
      checkOutput({vecs[i].name, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({vecs[i].name, "_instr"}, outInstr, vecs[i].expInstr);
      checkOutput({vecs[i].name, "_addr"}, outAddr, BASE + 32'(4 * i));
      tick();
    end

    // Backpressure: three back-to-back requests into a two-entry buffer.
    doReset();
    vA = vecs[0];
    vB = vecs[1];
    vC = vecs[2];
    applyVec(1'b1, vA);
    @(negedge clk);
    checkOutput("bp_ready0", 32'(inReady), 32'd1);
    tick();
    applyVec(1'b1, vB);
    @(negedge clk);
    checkOutput("bp_ready1", 32'(inReady), 32'd1);
    tick();
    applyVec(1'b1, vC);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_full", 32'(inReady), 32'd0);
      checkOutput("bp_stall_valid", 32'(outValid), 32'd1);
      checkOutput("bp_stall_instr", outInstr, vA.expInstr);
      checkOutput("bp_stall_addr", outAddr, BASE);
      tick();
    end
    outReady = 1'b1;
    gotQ.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outValid) gotQ.push_back('{outInstr, outAddr});
      acceptNow = inValid && inReady;
      tick();
      if (acceptNow) applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    end
    checkOutput("bp_count", 32'(gotQ.size()), 32'd3);
    if (gotQ.size() == 3) begin
      checkOutput("bp_instr0", gotQ[0].instr, vA.expInstr);
      checkOutput("bp_addr0", gotQ[0].addr, BASE);
      checkOutput("bp_instr1", gotQ[1].instr, vB.expInstr);
      checkOutput("bp_addr1", gotQ[1].addr, BASE + 32'd4);
      checkOutput("bp_instr2", gotQ[2].instr, vC.expInstr);
      checkOutput("bp_addr2", gotQ[2].addr, BASE + 32'd8);
    end

    // Illegal request: dropped, one-cycle err, address counter untouched.
    doReset();
    outReady = 1'b1;
    applyStimulus(1'b1, 3'd7, 4'd0, 5'd1, 5'd1, 5'd1, 32'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("ill_err", 32'(err), 32'd1);
    checkOutput("ill_err_cnt", 32'(errCnt), 32'd1);
    checkOutput("ill_no_push", 32'(outValid), 32'd0);
    applyVec(1'b1, vecs[8]);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("ill_err_pulse", 32'(err), 32'd0);
    checkOutput("ill_next_valid", 32'(outValid), 32'd1);
    checkOutput("ill_next_instr", outInstr, vecs[8].expInstr);
    checkOutput("ill_next_addr", outAddr, BASE);
    tick();
`ifdef INSTR_ENC_RANGE_CHECK_EN
    applyStimulus(1'b1, 3'd3, 4'b0000, 5'd1, 5'd1, 5'd0, 32'd2048);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("rng_err", 32'(err), 32'd1);
    checkOutput("rng_err_cnt", 32'(errCnt), 32'd2);
    checkOutput("rng_no_push", 32'(outValid), 32'd0);
    tick();
`endif

    // err_cnt saturates at 255.
    doReset();
    applyStimulus(1'b1, 3'd7, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    repeat (260) tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("sat_err_cnt", 32'(errCnt), 32'd255);
    checkOutput("sat_err", 32'(err), 32'd1);
    tick();

    // Reset with two words buffered flushes them and restarts the address.
    doReset();
    applyVec(1'b1, vecs[3]);
    tick();
    applyVec(1'b1, vecs[4]);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("mid_full_valid", 32'(outValid), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_ready_in_rst", 32'(inReady), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("mid_flush", 32'(outValid), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_ready_after", 32'(inReady), 32'd1);
    applyVec(1'b1, vecs[5]);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("mid_next_instr", outInstr, vecs[5].expInstr);
    checkOutput("mid_next_addr", outAddr, BASE);
    tick();

    // Address wrap on the second instance.
    inValid2 = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("wrap_valid0", 32'(outValid2), 32'd1);
    checkOutput("wrap_addr0", outAddr2, BASE2);
    checkOutput("wrap_instr0", outInstr2, 32'h0031_00B3);
    tick();
    inValid2 = 1'b0;
    @(negedge clk);
    checkOutput("wrap_addr1", outAddr2, 32'h0000_0000);
    tick();

    // Random traffic against the queue model.
    doReset();
    expQ.delete();
    modelAddr   = BASE;
    modelErrCnt = 0;
    modelErr    = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v  = ($urandom_range(0, 3) != 0);
      t  = 3'($urandom_range(0, 7));
      op = 4'($urandom);
      case ($urandom_range(0, 3))
        0: imm = int'($urandom_range(0, 127)) - 64;
        1: imm = 2 * (int'($urandom_range(0, 4095)) - 2048);
        2: imm = int'($urandom_range(0, 31));
        default: imm = int'($urandom) & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 7) == 0) imm = int'($urandom);
      immV = 32'(imm);
      applyStimulus(v, t, op, 5'($urandom), 5'($urandom), 5'($urandom), immV);
      outReady = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checkOutput("rnd_out_valid", 32'(outValid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("rnd_instr", outInstr, expQ[0].instr);
        checkOutput("rnd_addr", outAddr, expQ[0].addr);
      end
      checkOutput("rnd_in_ready", 32'(inReady), 32'(expQ.size() < DEPTH));
      checkOutput("rnd_err", 32'(err), 32'(modelErr));
      checkOutput("rnd_err_cnt", 32'(errCnt), 32'(modelErrCnt));
      readyNow = (expQ.size() < DEPTH);
      if (expQ.size() != 0 && outReady) void'(expQ.pop_front());
      modelErr = 1'b0;
      if (v && readyNow) begin
        legalNow = modelLegal(t, op, immV);
        if (legalNow) begin
          expQ.push_back('{modelEncode(t, op, inRd, inRs1, inRs2, immV), modelAddr});
          modelAddr = modelAddr + 32'd4;
        end else begin
          modelErr = 1'b1;
          if (modelErrCnt < 255) modelErrCnt++;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
